decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/decode_issue_imm_gen.sv | 27 ++
 rtl/decode_issue.sv | 217 +++++++++++++++++++++
 tb/tb_decode_issue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32I opcode constants and immediate-format encoding
// shared by the decode/issue stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/decode_issue_imm_gen.sv
// Combinational RV32I immediate extraction with sign extension.
// Opcode bits are not needed here; the format is selected upstream.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage with pending-write scoreboard.
// Define DECODE_BYPASS_EN to forward writeback data into issue.
module decode_issue
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic [4:0]  rf_rd1_idx,
  output logic [4:0]  rf_rd2_idx,
  output logic        rf_rd1_en,
  output logic        rf_rd2_en,
  input  logic [31:0] rf_rd1_data,
  input  logic [31:0] rf_rd2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_idx,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal,
  input  logic        flush
);

  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, legal, no_rd;
  imm_fmt_e    fmt;
  logic [31:0] imm;
  logic        rd_we, hazard, accept;
  logic        byp1, byp2;

  assign opc = in_instr[6:0];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  always_comb begin
    use1  = 1'b0;
    use2  = 1'b0;
    legal = 1'b1;
    no_rd = 1'b0;
    fmt   = IMM_NONE;
    unique case (opc)
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL: fmt = IMM_J;
      OPC_JALR: begin
        use1 = 1'b1;
        fmt  = IMM_I;
      end
      OPC_BRANCH: begin
        use1  = 1'b1;
        use2  = 1'b1;
        no_rd = 1'b1;
        fmt   = IMM_B;
      end
      OPC_LOAD: begin
        use1 = 1'b1;
        fmt  = IMM_I;
      end
      OPC_STORE: begin
        use1  = 1'b1;
        use2  = 1'b1;
        no_rd = 1'b1;
        fmt   = IMM_S;
      end
      OPC_OP_IMM: begin
        use1 = 1'b1;
        fmt  = IMM_I;
      end
      OPC_OP: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign rf_rd1_idx = rs1;
  assign rf_rd2_idx = rs2;
  assign rf_rd1_en  = in_valid & use1;
  assign rf_rd2_en  = in_valid & use2;

  assign rd_we = legal & ~no_rd & (rd != 5'd0);

`ifdef DECODE_BYPASS_EN
  assign byp1 = wb_valid && (wb_idx != 5'd0) &&
                (wb_idx == rs1) && rf_rd1_en;
  assign byp2 = wb_valid && (wb_idx != 5'd0) &&
                (wb_idx == rs2) && rf_rd2_en;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  logic [31:0] pending_q, pending_d;

  assign hazard = (rf_rd1_en & pending_q[rs1] & ~byp1) |
                  (rf_rd2_en & pending_q[rs2] & ~byp2);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_rs1_q, out_rs1_d;
  logic [31:0] out_rs2_q, out_rs2_d;
  logic [31:0] out_imm_q, out_imm_d;
  logic [6:0]  out_opc_q, out_opc_d;
  logic [2:0]  out_f3_q, out_f3_d;
  logic        out_f7_q, out_f7_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_we_q, out_we_d;
  logic        out_ill_q, out_ill_d;

  assign in_ready = ~reset & (~out_valid_q | out_ready) &
                    ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // Set after clears so a same-edge set/clear leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (flush && out_valid_q && out_we_q)
      pending_d[out_rd_q] = 1'b0;
    if (wb_valid)
      pending_d[wb_idx] = 1'b0;
    if (accept && rd_we)
      pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_imm_d   = out_imm_q;
    out_opc_d   = out_opc_q;
    out_f3_d    = out_f3_q;
    out_f7_d    = out_f7_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    out_ill_d   = out_ill_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_rs1_d   = byp1 ? wb_data : rf_rd1_data;
      out_rs2_d   = byp2 ? wb_data : rf_rd2_data;
      out_imm_d   = imm;
      out_opc_d   = opc;
      out_f3_d    = in_instr[14:12];
      out_f7_d    = in_instr[30];
      out_rd_d    = rd;
      out_we_d    = rd_we;
      out_ill_d   = ~legal;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      out_opc_q   <= '0;
      out_f3_q    <= '0;
      out_f7_q    <= 1'b0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_imm_q   <= out_imm_d;
      out_opc_q   <= out_opc_d;
      out_f3_q    <= out_f3_d;
      out_f7_q    <= out_f7_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rs1_val  = out_rs1_q;
  assign out_rs2_val  = out_rs2_q;
  assign out_imm      = out_imm_q;
  assign out_opcode   = out_opc_q;
  assign out_funct3   = out_f3_q;
  assign out_funct7b5 = out_f7_q;
  assign out_rd       = out_rd_q;
  assign out_rd_we    = out_we_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected entries queued at
// accept, compared when the issue port hands them downstream.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr, in_pc;
  logic        in_ready;
  logic [4:0]  rf_rd1_idx, rf_rd2_idx;
  logic        rf_rd1_en, rf_rd2_en;
  logic [31:0] rf_rd1_data, rf_rd2_data;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_illegal;
  logic        flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_ready     (in_ready),
    .rf_rd1_idx   (rf_rd1_idx),
    .rf_rd2_idx   (rf_rd2_idx),
    .rf_rd1_en    (rf_rd1_en),
    .rf_rd2_en    (rf_rd2_en),
    .rf_rd1_data  (rf_rd1_data),
    .rf_rd2_data  (rf_rd2_data),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_imm      (out_imm),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .out_illegal  (out_illegal),
    .flush        (flush)
  );

  function automatic logic [31:0] rfv(input logic [4:0] i);
    return 32'h1000_0000 + {27'd0, i} * 32'h111;
  endfunction

  function automatic logic [31:0] wbv(input logic [4:0] i);
    return 32'hBEEF_0000 | {27'd0, i};
  endfunction

  assign rf_rd1_data = rfv(rf_rd1_idx);
  assign rf_rd2_data = rfv(rf_rd2_idx);

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input logic [31:0] ins, pc, imm,
                              input logic we, ill);
    exp_t e;
    e.pc  = pc;
    e.rs1 = rfv(ins[19:15]);
    e.rs2 = rfv(ins[24:20]);
    e.imm = imm;
    e.opc = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[30];
    e.rd  = ins[11:7];
    e.we  = we;
    e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pc",  out_pc, e.pc);
        chk("rs1", out_rs1_val, e.rs1);
        chk("rs2", out_rs2_val, e.rs2);
        chk("imm", out_imm, e.imm);
        chk("opc", {25'd0, out_opcode}, {25'd0, e.opc});
        chk("f3",  {29'd0, out_funct3}, {29'd0, e.f3});
        chk("f7",  {31'd0, out_funct7b5}, {31'd0, e.f7});
        chk("rd",  {27'd0, out_rd}, {27'd0, e.rd});
        chk("we",  {31'd0, out_rd_we}, {31'd0, e.we});
        chk("ill", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  logic [31:0] pc = 32'h100;

  task automatic send(input logic [31:0] ins, imm,
                      input logic we, ill, rdy0);
    exp_t e;
    bit   done;
    e = mk(ins, pc, imm, we, ill);
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    done     = 1'b0;
    pc       = pc + 32'd4;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rdy0 && i == 0)
        chk("rdy_first", {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic hazard_wb(input logic [31:0] ins, imm,
                           input logic [4:0] widx);
    exp_t e;
    e = mk(ins, pc, imm, 1'b0, 1'b0);
    e.we = (ins[6:0] == 7'b0110011) && (ins[11:7] != 5'd0);
    in_instr = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    pc       = pc + 32'd4;
    @(negedge clk);
    chk("haz_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("haz_hold", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b1;
    wb_idx   = widx;
    wb_data  = wbv(widx);
`ifdef DECODE_BYPASS_EN
    if (ins[19:15] == widx) e.rs1 = wbv(widx);
    if (ins[24:20] == widx) e.rs2 = wbv(widx);
    @(negedge clk);
    chk("byp_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(e);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    in_valid = 1'b0;
`else
    @(negedge clk);
    chk("wb_cycle_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("wb_next_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
    out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // addi x1,x0,5
    send(32'h00500093, 32'd5, 1'b1, 1'b0, 1'b1);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_rd", {27'd0, out_rd}, 32'd1);

    // add x2,x1,x1 waits on x1
    hazard_wb(32'h00108133, 32'd0, 5'd1);
    @(posedge clk); #1;

    // hold a lui for three cycles
    out_ready = 1'b0;
    send(32'h123453B7, 32'h12345000, 1'b1, 1'b0, 1'b1);
    in_instr = 32'h00100413;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_imm", out_imm, 32'h12345000);
      chk("stall_rd", {27'd0, out_rd}, 32'd7);
      chk("stall_pc", out_pc, pc - 32'd4);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("resume_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(mk(32'h00100413, pc, 32'd1, 1'b1, 1'b0));
    pc = pc + 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // beq waits on x2 via rs2
    hazard_wb(32'hFE208EE3, 32'hFFFFFFFC, 5'd2);
    send(32'h000E8513, 32'd0, 1'b1, 1'b0, 1'b1);
    send(32'h0080006F, 32'd8, 1'b0, 1'b0, 1'b1);
    send(32'hFE002E23, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
    send(32'h00001297, 32'h00001000, 1'b1, 1'b0, 1'b1);

    // illegal opcode must not mark x4
    send(32'h0000027F, 32'd0, 1'b0, 1'b1, 1'b1);
    send(32'h00020593, 32'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;

    // flush a held addi x3
    out_ready = 1'b0;
    send(32'h00100193, 32'd1, 1'b1, 1'b0, 1'b1);
    in_instr = 32'h00018633;
    in_pc    = pc;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    void'(q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("flush_pend3", {31'd0, in_ready}, 32'd1);
    q.push_back(mk(32'h00018633, pc, 32'd0, 1'b1, 1'b0));
    pc = pc + 32'd4;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // accept rd=4 with wb of x4 in the same cycle
    wb_valid = 1'b1;
    wb_idx   = 5'd4;
    wb_data  = wbv(5'd4);
    send(32'h00700213, 32'd7, 1'b1, 1'b0, 1'b1);
    wb_valid = 1'b0;
    in_instr = 32'h00020693;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("pend4_set", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end

    // reset in the middle of the stall
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_imm", out_imm, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_rd", {26'd0, out_rd, out_rd_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    @(negedge clk) reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(mk(32'h00020693, pc, 32'd0, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
